program_loader: RTL and testbench

- Upstream feeder for the pipelined CPU's byte-wide program memory write port.
- Accepts a framed byte stream over a valid/ready handshake: length byte, data bytes, XOR checksum byte.
- Drives the memory write strobe, address and data, one byte per write, at consecutive addresses from 0.
- Holds the CPU in reset until a frame is verified.

---
 rtl/loader_pkg.sv | 36 +++
 rtl/xor_checksum.sv | 49 ++++
 rtl/program_loader.sv | 150 +++++++++++++++
 tb/tb_program_loader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the program loader.
//   - state encoding for the frame FSM; the LEN -> DATA -> CSUM framing order
//     is carried by consecutive codes
//   - MAX_LEN: largest accepted frame length for the default address width
//   - helper functions used by the loader datapath
// -----------------------------------------------------------------------------
package loader_pkg;

    localparam int ADD_WIDTH_DEF = 7;
    localparam int MAX_LEN       = 2 ** ADD_WIDTH_DEF;

    typedef logic [2:0] state_t;

    // Frame phases use consecutive codes so the framing order reads directly
    // from the encoding: LEN, then DATA, then CSUM.
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_LEN  = 3'd1;
    localparam state_t ST_DATA = 3'd2;
    localparam state_t ST_CSUM = 3'd3;
    localparam state_t ST_RUN  = 3'd4;
    localparam state_t ST_ERR  = 3'd5;

    // High while the loader is inside a frame and may take stream bytes.
    function automatic logic in_frame(input state_t s);
        return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

    // A length byte is usable when it is non-zero and fits in program memory.
    function automatic logic len_valid(input logic [31:0] len,
                                       input logic [31:0] max_len);
        return (len != 32'd0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/xor_checksum.sv
// -----------------------------------------------------------------------------
// xor_checksum
// Running XOR checksum register for the program loader.
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-low reset
//   clr    in   clear the checksum to zero (highest priority)
//   load   in   load din as the new checksum
//   acc    in   XOR din into the checksum
//   din    in   DATA_WIDTH data byte
//   csum   out  DATA_WIDTH current checksum value
// -----------------------------------------------------------------------------
module xor_checksum #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  load,
    input  logic                  acc,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] csum
);

    logic [DATA_WIDTH-1:0] csum_q;
    logic [DATA_WIDTH-1:0] csum_d;

    always_comb begin
        csum_d = csum_q;
        if (clr) begin
            csum_d = '0;
        end else if (load) begin
            csum_d = din;
        end else if (acc) begin
            csum_d = csum_q ^ din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign csum = csum_q;

endmodule

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
// Receives a framed byte stream (length, data bytes, XOR checksum) over a
// valid/ready handshake and writes the data bytes into the CPU's program
// memory at consecutive addresses from 0. The CPU is held in reset until a
// frame has been loaded and its checksum verified.
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-low reset
//   load_start  in   one-cycle pulse; starts or restarts a frame
//   byte_in     in   DATA_WIDTH stream byte
//   byte_valid  in   byte_in valid
//   byte_ready  out  loader accepts byte_in this cycle (combinational)
//   pm_wr_en    out  program memory write strobe
//   pm_addr     out  ADD_WIDTH program memory write address
//   pm_data     out  DATA_WIDTH program memory write data
//   cpu_hold    out  CPU must be held in reset while high
//   load_done   out  frame loaded and checksum matched
//   load_error  out  frame rejected
// -----------------------------------------------------------------------------
module program_loader
    import loader_pkg::*;
#(
    parameter int ADD_WIDTH  = 7,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic [DATA_WIDTH-1:0] byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  pm_wr_en,
    output logic [ADD_WIDTH-1:0]  pm_addr,
    output logic [DATA_WIDTH-1:0] pm_data,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error
);

    // One extra bit so a full-memory length (2**ADD_WIDTH) is representable.
    localparam int          LEN_W   = ADD_WIDTH + 1;
    localparam logic [31:0] LEN_MAX = 32'(1) << ADD_WIDTH;

    state_t                state_q,    state_d;
    logic [LEN_W-1:0]      len_q,      len_d;
    logic [LEN_W-1:0]      idx_q,      idx_d;
    logic                  pm_wr_en_q, pm_wr_en_d;
    logic [ADD_WIDTH-1:0]  pm_addr_q,  pm_addr_d;
    logic [DATA_WIDTH-1:0] pm_data_q,  pm_data_d;

    logic                  accept;
    logic                  idx_last;
    logic                  csum_clr;
    logic                  csum_load;
    logic                  csum_acc;
    logic [DATA_WIDTH-1:0] csum;

    // load_start takes priority over the stream, so a byte presented in the
    // same cycle is refused rather than silently dropped.
    assign byte_ready = in_frame(state_q) && !load_start;
    assign accept     = byte_valid && byte_ready;
    assign idx_last   = (idx_q == (len_q - LEN_W'(1)));

    xor_checksum #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_csum (
        .clk  (clk),
        .rst  (rst),
        .clr  (csum_clr),
        .load (csum_load),
        .acc  (csum_acc),
        .din  (byte_in),
        .csum (csum)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        pm_wr_en_d = 1'b0;
        pm_addr_d  = pm_addr_q;
        pm_data_d  = pm_data_q;
        csum_clr   = 1'b0;
        csum_load  = 1'b0;
        csum_acc   = 1'b0;

        if (load_start) begin
            // Start or abort from any state. A write registered in the
            // previous cycle is already on the outputs and still completes.
            state_d  = ST_LEN;
            idx_d    = '0;
            csum_clr = 1'b1;
        end else if (accept) begin
            case (state_q)
                ST_LEN: begin
                    len_d     = byte_in[LEN_W-1:0];
                    idx_d     = '0;
                    csum_load = 1'b1;
                    state_d   = len_valid(32'(byte_in), LEN_MAX) ? ST_DATA : ST_ERR;
                end
                ST_DATA: begin
                    // Registered write: strobe appears the cycle after acceptance.
                    pm_wr_en_d = 1'b1;
                    pm_addr_d  = idx_q[ADD_WIDTH-1:0];
                    pm_data_d  = byte_in;
                    csum_acc   = 1'b1;
                    idx_d      = idx_q + LEN_W'(1);
                    if (idx_last) begin
                        state_d = ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    state_d = (byte_in == csum) ? ST_RUN : ST_ERR;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            idx_q      <= '0;
            pm_wr_en_q <= 1'b0;
            pm_addr_q  <= '0;
            pm_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            pm_wr_en_q <= pm_wr_en_d;
            pm_addr_q  <= pm_addr_d;
            pm_data_q  <= pm_data_d;
        end
    end

    assign pm_wr_en   = pm_wr_en_q;
    assign pm_addr    = pm_addr_q;
    assign pm_data    = pm_data_q;

    // The CPU runs only in RUN; every other state keeps it in reset. Writes
    // can only follow DATA acceptances, which all precede RUN.
    assign cpu_hold   = (state_q != ST_RUN);
    assign load_done  = (state_q == ST_RUN);
    assign load_error = (state_q == ST_ERR);

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    localparam int AW = 7;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load_start = 1'b0;
    logic [DW-1:0] byte_in = '0;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic          pm_wr_en;
    logic [AW-1:0] pm_addr;
    logic [DW-1:0] pm_data;
    logic          cpu_hold;
    logic          load_done;
    logic          load_error;

    always #5 clk = ~clk;

    program_loader #(
        .ADD_WIDTH  (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .pm_wr_en   (pm_wr_en),
        .pm_addr    (pm_addr),
        .pm_data    (pm_data),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Expected memory write with the monitor cycle in which it must appear.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [31:0]   stamp;
    } wr_t;

    wr_t exp_q[$];

    // One frame per record: stimulus plus expected end state.
    typedef struct packed {
        logic [7:0]      len;
        logic [7:0]      ndata;
        logic [3:0][7:0] d;
        logic            use_fill;
        logic [7:0]      fill;
        logic            send_csum;
        logic [7:0]      csum;
        logic            gaps;
        logic            exp_done;
        logic            exp_err;
    } vec_t;

    vec_t vecs[6];

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Write monitor: samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        wr_t e;
        #1;
        cyc++;
        if (!rst) begin
            check("no_write_in_reset", 32'(pm_wr_en), 32'd0);
        end else begin
            while (exp_q.size() > 0 && exp_q[0].stamp < 32'(cyc)) begin
                n_tests++;
                n_fail++;
                $display("FAIL missing_write: got none, expected addr 0x%0h data 0x%0h",
                         exp_q[0].addr, exp_q[0].data);
                void'(exp_q.pop_front());
            end
            if (pm_wr_en) begin
                check("hold_during_write", 32'(cpu_hold), 32'd1);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                             pm_addr, pm_data);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr",  32'(pm_addr), 32'(e.addr));
                    check("wr_data",  32'(pm_data), 32'(e.data));
                    check("wr_cycle", 32'(cyc),     e.stamp);
                end
            end
        end
    end

    // Present one byte until accepted; a data byte queues its expected write.
    task automatic send(input logic [7:0] b, input bit is_wr, input int addr);
        bit ok = 1'b0;
        for (int w = 0; w < 20 && !ok; w++) begin
            @(negedge clk);
            byte_valid = 1'b1;
            byte_in    = b;
            #1;
            if (byte_ready) begin
                ok = 1'b1;
                if (is_wr) begin
                    exp_q.push_back('{addr: AW'(addr), data: b, stamp: 32'(cyc + 1)});
                end
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: byte 0x%0h got no byte_ready, expected ready", b);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            byte_valid = 1'b0;
        end
    endtask

    // load_start pulse with a competing byte; afterwards the loader is in LEN.
    task automatic pulse_start();
        @(negedge clk);
        load_start = 1'b1;
        byte_valid = 1'b1;
        byte_in    = 8'hCC;
        #1;
        check("ready_low_on_start", 32'(byte_ready), 32'd0);
        @(negedge clk);
        load_start = 1'b0;
        byte_valid = 1'b0;
        #1;
        check("len_hold",  32'(cpu_hold),   32'd1);
        check("len_done",  32'(load_done),  32'd0);
        check("len_error", 32'(load_error), 32'd0);
        check("len_ready", 32'(byte_ready), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        logic [7:0] last_b;

        vecs[0] = '{len: 8'h04, ndata: 8'd4, d: 32'h0000_0513, use_fill: 1'b0, fill: 8'h00,
                    send_csum: 1'b1, csum: 8'h12, gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
        vecs[1] = '{len: 8'h04, ndata: 8'd4, d: 32'h0000_0513, use_fill: 1'b0, fill: 8'h00,
                    send_csum: 1'b1, csum: 8'h13, gaps: 1'b0, exp_done: 1'b0, exp_err: 1'b1};
        vecs[2] = '{len: 8'h00, ndata: 8'd0, d: 32'h0, use_fill: 1'b0, fill: 8'h00,
                    send_csum: 1'b0, csum: 8'h00, gaps: 1'b0, exp_done: 1'b0, exp_err: 1'b1};
        vecs[3] = '{len: 8'h81, ndata: 8'd0, d: 32'h0, use_fill: 1'b0, fill: 8'h00,
                    send_csum: 1'b0, csum: 8'h00, gaps: 1'b0, exp_done: 1'b0, exp_err: 1'b1};
        vecs[4] = '{len: 8'h80, ndata: 8'd128, d: 32'h0, use_fill: 1'b1, fill: 8'hA5,
                    send_csum: 1'b1, csum: 8'h80, gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
        vecs[5] = '{len: 8'h03, ndata: 8'd3, d: 32'h0033_2211, use_fill: 1'b0, fill: 8'h00,
                    send_csum: 1'b1, csum: 8'h03, gaps: 1'b1, exp_done: 1'b1, exp_err: 1'b0};

        // Reset state, with a byte offered in IDLE.
        byte_valid = 1'b1;
        byte_in    = 8'h04;
        repeat (3) @(negedge clk);
        check("rst_wr_en", 32'(pm_wr_en),   32'd0);
        check("rst_addr",  32'(pm_addr),    32'd0);
        check("rst_data",  32'(pm_data),    32'd0);
        check("rst_hold",  32'(cpu_hold),   32'd1);
        check("rst_done",  32'(load_done),  32'd0);
        check("rst_error", 32'(load_error), 32'd0);
        rst = 1'b1;
        idle(2);
        byte_valid = 1'b1;
        #1;
        check("idle_ready", 32'(byte_ready), 32'd0);
        check("idle_hold",  32'(cpu_hold),   32'd1);
        idle(1);

        // Table-driven frames.
        for (int v = 0; v < 6; v++) begin
            last_b = 8'h00;
            pulse_start();
            send(vecs[v].len, 1'b0, 0);
            for (int i = 0; i < int'(vecs[v].ndata); i++) begin
                b = vecs[v].use_fill ? vecs[v].fill : vecs[v].d[i % 4];
                send(b, 1'b1, i);
                last_b = b;
                if (vecs[v].gaps) idle(1);
            end
            if (vecs[v].send_csum) send(vecs[v].csum, 1'b0, 0);
            idle(3);
            check($sformatf("frame%0d_done", v),  32'(load_done),  32'(vecs[v].exp_done));
            check($sformatf("frame%0d_error", v), 32'(load_error), 32'(vecs[v].exp_err));
            check($sformatf("frame%0d_hold", v),  32'(cpu_hold),   32'(!vecs[v].exp_done));
            check($sformatf("frame%0d_pending", v), 32'(exp_q.size()), 32'd0);
            if (vecs[v].ndata != 8'd0) begin
                check($sformatf("frame%0d_last_addr", v), 32'(pm_addr), 32'(vecs[v].ndata) - 32'd1);
                check($sformatf("frame%0d_last_data", v), 32'(pm_data), 32'(last_b));
            end
        end

        // Abort after two data bytes, then a full L=1 frame.
        pulse_start();
        send(8'h04, 1'b0, 0);
        send(8'hAA, 1'b1, 0);
        send(8'hBB, 1'b1, 1);
        pulse_start();
        send(8'h01, 1'b0, 0);
        send(8'h77, 1'b1, 0);
        send(8'h76, 1'b0, 0);
        idle(3);
        check("abort_done",    32'(load_done),    32'd1);
        check("abort_hold",    32'(cpu_hold),     32'd0);
        check("abort_error",   32'(load_error),   32'd0);
        check("abort_pending", 32'(exp_q.size()), 32'd0);

        // Bytes offered in RUN are refused.
        @(negedge clk);
        byte_valid = 1'b1;
        byte_in    = 8'h01;
        #1;
        check("run_ready", 32'(byte_ready), 32'd0);
        idle(2);
        check("run_still_done", 32'(load_done), 32'd1);

        // Reload from RUN: cpu_hold rises the cycle after load_start.
        @(negedge clk);
        load_start = 1'b1;
        #1;
        check("reload_hold_same_cycle", 32'(cpu_hold),  32'd0);
        check("reload_done_same_cycle", 32'(load_done), 32'd1);
        @(negedge clk);
        load_start = 1'b0;
        #1;
        check("reload_hold_next", 32'(cpu_hold),  32'd1);
        check("reload_done_next", 32'(load_done), 32'd0);

        // Reset mid-frame while a write is on the outputs and a byte is offered.
        send(8'h04, 1'b0, 0);
        send(8'h55, 1'b1, 0);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_in    = 8'h66;
        #1;
        rst = 1'b0;
        #1;
        check("midrst_wr_en", 32'(pm_wr_en),   32'd0);
        check("midrst_hold",  32'(cpu_hold),   32'd1);
        check("midrst_done",  32'(load_done),  32'd0);
        check("midrst_error", 32'(load_error), 32'd0);
        check("midrst_ready", 32'(byte_ready), 32'd0);
        check("midrst_addr",  32'(pm_addr),    32'd0);
        check("midrst_data",  32'(pm_data),    32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_rst_ready", 32'(byte_ready), 32'd0);
        idle(3);
        check("post_rst_wr_en",   32'(pm_wr_en),     32'd0);
        check("post_rst_hold",    32'(cpu_hold),     32'd1);
        check("post_rst_pending", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
